// File: rtl/uart_rx_fifo.sv
// Receive-side FWFT buffer between the UART receiver and the CPU port.
// Drains each rx_new byte with a one-cycle uart_read acknowledge and tracks full/overflow status.
module uart_rx_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clki,
    input  logic          rst_in,
    input  logic [7:0]    rx_data,
    input  logic          rx_new,
    output logic          uart_read,
    input  logic          pop,
    input  logic          clr_ovf,
    output logic [7:0]    dout,
    output logic          nonempty,
    output logic          full,
    output logic          ovf,
    output logic [AW:0]   count
);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] wp_q, wp_d;
    logic [AW-1:0] rp_q, rp_d;
    logic [AW:0]   count_q, count_d;
    logic          ovf_q, ovf_d;
    logic [7:0]    mem_q [DEPTH];

    logic push_try;
    logic push_ok;
    logic pop_eff;

    assign full     = (count_q == (AW+1)'(DEPTH));
    assign nonempty = (count_q != '0);
    assign count    = count_q;
    assign ovf      = ovf_q;
    assign dout     = nonempty ? mem_q[rp_q] : '0;

    // Acknowledge is gated by reset so it drops at once even with rx_new still high.
    always_comb begin
        state_d   = state_q;
        uart_read = 1'b0;
        push_try  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rx_new && rst_in) begin
                    uart_read = 1'b1;
                    push_try  = 1'b1;
                    state_d   = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!rx_new) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        pop_eff = pop && nonempty;
        push_ok = push_try && (!full || pop_eff);

        wp_d    = push_ok ? wp_q + AW'(1) : wp_q;
        rp_d    = pop_eff ? rp_q + AW'(1) : rp_q;

        count_d = count_q;
        if (push_ok && !pop_eff) begin
            count_d = count_q + (AW+1)'(1);
        end else if (pop_eff && !push_ok) begin
            count_d = count_q - (AW+1)'(1);
        end

        ovf_d = ovf_q;
        if (push_try && !push_ok) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clki or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= S_IDLE;
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge clki) begin
        if (push_ok) begin
            mem_q[wp_q] <= rx_data;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed + randomized bench for uart_rx_fifo against a queue-based model of the buffer.
module tb_uart_rx_fifo;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned AW    = 4;

    logic          clki;
    logic          rst_in;
    logic [7:0]    rx_data;
    logic          rx_new;
    logic          uart_read;
    logic          pop;
    logic          clr_ovf;
    logic [7:0]    dout;
    logic          nonempty;
    logic          full;
    logic          ovf;
    logic [AW:0]   count;

    uart_rx_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clki      (clki),
        .rst_in    (rst_in),
        .rx_data   (rx_data),
        .rx_new    (rx_new),
        .uart_read (uart_read),
        .pop       (pop),
        .clr_ovf   (clr_ovf),
        .dout      (dout),
        .nonempty  (nonempty),
        .full      (full),
        .ovf       (ovf),
        .count     (count)
    );

    initial clki = 1'b0;
    always #5 clki = ~clki;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: byte queue, sticky overflow bit, and whether the
    // UART side has dropped rx_new since the last acknowledge.
    logic [7:0] q [$];
    bit         ovf_m;
    bit         armed;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        ovf_m = 1'b0;
        armed = 1'b1;
    endtask

    task automatic chk_outputs(input string tag);
        logic [7:0] head;
        head = (q.size() > 0) ? q[0] : 8'h00;
        chk({tag, ".count"},    32'(count),    32'(q.size()));
        chk({tag, ".nonempty"}, 32'(nonempty), 32'(q.size() != 0));
        chk({tag, ".full"},     32'(full),     32'(q.size() == DEPTH));
        chk({tag, ".ovf"},      32'(ovf),      32'(ovf_m));
        chk({tag, ".dout"},     32'(dout),     32'(head));
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, ".uart_read"}, 32'(uart_read), 32'd0);
        chk({tag, ".dout"},      32'(dout),      32'd0);
        chk({tag, ".nonempty"},  32'(nonempty),  32'd0);
        chk({tag, ".full"},      32'(full),      32'd0);
        chk({tag, ".ovf"},       32'(ovf),       32'd0);
        chk({tag, ".count"},     32'(count),     32'd0);
    endtask

    // One clock cycle: called at a negedge, drives inputs, checks the
    // acknowledge combinationally, then checks registered state at the next negedge.
    task automatic step(input logic rxn, input logic [7:0] d, input logic p, input logic c);
        bit exp_ur;
        bit pop_eff;
        rx_new  = rxn;
        rx_data = d;
        pop     = p;
        clr_ovf = c;
        #1;
        exp_ur = armed && rxn;
        chk("uart_read", 32'(uart_read), 32'(exp_ur));
        @(posedge clki);
        pop_eff = p && (q.size() > 0);
        if (pop_eff) void'(q.pop_front());
        if (exp_ur && q.size() >= DEPTH) begin
            ovf_m = 1'b1;
        end else begin
            if (exp_ur) q.push_back(d);
            if (c) ovf_m = 1'b0;
        end
        if (exp_ur)    armed = 1'b0;
        else if (!rxn) armed = 1'b1;
        @(negedge clki);
        chk_outputs("step");
    endtask

    // UART-style byte delivery: rx_new held until one cycle after the acknowledge.
    task automatic send(input logic [7:0] d, input logic p1, input logic p2, input logic c);
        step(1'b1, d, p1, c);
        step(1'b1, d, p2, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (q.size() > 0 && guard < 64) begin
            step(1'b0, 8'h00, 1'b1, 1'b0);
            guard++;
        end
        chk("drain.empty", 32'(nonempty), 32'd0);
    endtask

    initial begin
        rst_in  = 1'b1;
        rx_new  = 1'b0;
        rx_data = 8'h00;
        pop     = 1'b0;
        clr_ovf = 1'b0;
        model_reset();

        // Reset held for three cycles, then idle.
        @(negedge clki);
        rst_in = 1'b0;
        repeat (3) @(posedge clki);
        @(negedge clki);
        chk_reset_values("reset");
        rst_in = 1'b1;
        repeat (10) step(1'b0, 8'h00, 1'b0, 1'b0);

        // Single byte then one pop.
        send(8'h41, 1'b0, 1'b0, 1'b0);
        chk("single.dout", 32'(dout), 32'h41);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("single.after_pop", 32'(count), 32'd0);

        // Fill with 17 bytes; the last one is dropped.
        for (int i = 0; i < 17; i++) send(8'(i), 1'b0, 1'b0, 1'b0);
        chk("fill.full", 32'(full), 32'd1);
        chk("fill.ovf",  32'(ovf),  32'd1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        chk("clr.ovf", 32'(ovf), 32'd0);
        for (int i = 0; i < 16; i++) begin
            chk("fill.order", 32'(dout), 32'(i));
            step(1'b0, 8'h00, 1'b1, 1'b0);
        end

        // Push with pop on a full FIFO.
        for (int i = 0; i < 16; i++) send(8'(i), 1'b0, 1'b0, 1'b0);
        send(8'hAA, 1'b1, 1'b0, 1'b0);
        chk("fullpp.count", 32'(count), 32'd16);
        chk("fullpp.head",  32'(dout),  32'h01);
        chk("fullpp.ovf",   32'(ovf),   32'd0);
        for (int i = 0; i < 15; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("fullpp.last", 32'(dout), 32'hAA);
        drain();

        // Wrap-around with interleaved pops, kept below full.
        for (int i = 0; i < 40; i++) begin
            bit p;
            p = (q.size() >= 12) || ($urandom_range(0, 2) == 0);
            send(8'(i * 3), p, 1'b0, 1'b0);
            repeat ($urandom_range(0, 2)) step(1'b0, 8'h00, 1'($urandom_range(0, 1)), 1'b0);
            chk("wrap.count_max", 32'(count <= 5'd16), 32'd1);
        end
        chk("wrap.ovf", 32'(ovf), 32'd0);
        drain();

        // rx_new held high for 5 cycles gives a single push.
        repeat (5) step(1'b1, 8'h55, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        chk("hold.count", 32'(count), 32'd1);
        drain();

        // clr_ovf coinciding with a new overflow leaves ovf set.
        for (int i = 0; i < 16; i++) send(8'($urandom), 1'b0, 1'b0, 1'b0);
        send(8'hEE, 1'b0, 1'b0, 1'b1);
        chk("ovf_prio", 32'(ovf), 32'd1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        drain();

        // Fully random traffic.
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 2) == 0),
                 1'($urandom_range(0, 7) == 0));
        end
        step(1'b0, 8'h00, 1'b0, 1'b0);
        drain();

        // Reset while waiting for rx_new to fall.
        send(8'h12, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h77, 1'b0, 1'b0);
        #2;
        rst_in = 1'b0;
        #1;
        chk_reset_values("midreset");
        model_reset();
        @(negedge clki);
        chk_reset_values("midreset.hold");
        rst_in = 1'b1;
        step(1'b1, 8'h77, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        chk("recapture.dout", 32'(dout), 32'h77);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side buffer between the `uart` receiver and the CPU memory-mapped port at 0x0001/0x0002. It drains each byte flagged by `rx_new`, acknowledges it to the UART with a one-cycle `uart_read` pulse, and stores it in a first-word-fall-through FIFO. The CPU then reads bytes at its own pace, so back-to-back serial bytes no longer overwrite each other. Status bits (non-empty, full, sticky overflow) replace the raw `rx_new` bit in the 0x0002 status word.

## Interface
Parameters:
- `DEPTH`, 16: number of entries; must be a power of two, from 2 to 256.
- `AW`, log2(`DEPTH`): pointer width.

Ports:
- `clki` in 1: the single clock; every register in the block updates on its rising edge.
- `rst_in` in 1: asynchronous reset, active-low, applied to all state.
- `rx_data` in 8: byte from the UART; valid while `rx_new`=1.
- `rx_new` in 1: UART byte-available level.
- `uart_read` out 1: one-cycle acknowledge to the UART, which clears `rx_new`.
- `pop` in 1: one-cycle pulse that consumes the head entry. It comes from the bus decode's read-done strobe, already synchronised to `clki`.
- `clr_ovf` in 1: one-cycle pulse that clears `ovf`.
- `dout` out 8: the head byte; 0x00 when the FIFO is empty.
- `nonempty` out 1: count != 0.
- `full` out 1: count == `DEPTH`.
- `ovf` out 1: sticky flag, set when a byte is dropped.
- `count` out `AW`+1: number of stored entries.

## Operation
- Storage:
  - `DEPTH`x8 register array, write pointer `wp` and read pointer `rp`, both `AW` bits.
  - Pointers wrap modulo `DEPTH` with natural overflow.
  - `count` is a separate `AW`+1-bit register.
- Capture FSM, two states:
  - IDLE: if `rx_new`=1, attempt a push of `rx_data`, assert `uart_read` for this single cycle, and go to WAIT.
  - WAIT: `uart_read`=0. Return to IDLE when `rx_new`=0. This prevents a second push of the same byte while the UART flag is still falling.
- Push attempt:
  - Succeeds if `full`=0, or if `full`=1 with a `pop` in the same cycle.
  - On success: `mem[wp]<=rx_data`, and `wp` increments.
  - Otherwise the byte is discarded and `ovf` is set to 1.
  - The UART is acknowledged in both cases.
- Pop:
  - When `pop`=1 and `nonempty`=1, `rp` increments.
  - `pop` on an empty FIFO is ignored; there is no underflow flag and no state change.
- `count` update:
  - +1 on a successful push with no effective pop.
  - -1 on an effective pop with no push.
  - Unchanged when both or neither occur.
- `ovf`:
  - Set takes priority over `clr_ovf` in the same cycle.
  - Otherwise `clr_ovf` clears it.
- `dout` is `mem[rp]` when `nonempty`, else 0x00 (combinational mux on registered state).

## Timing
- Reset (`rst_in`=0, asynchronous):
  - `wp`=`rp`=0, `count`=0, FSM=IDLE, `ovf`=0.
  - Outputs: `uart_read`=0, `dout`=0x00, `nonempty`=0, `full`=0.
  - Memory contents are not reset.
- Reset deassertion is treated as synchronous by the integrator. If reset hits mid-handshake, the FSM returns to IDLE. A still-high `rx_new` is then re-captured once after reset; this is accepted.
- Push latency: `rx_new` rising at edge N gives capture and `uart_read`=1 during cycle N→N+1. `nonempty`/`dout` are valid after edge N+1.
- Minimum spacing between captures is 2 cycles (IDLE→WAIT→IDLE), assuming `rx_new` drops the cycle after `uart_read`.
- Pop: the next `dout` is valid after the edge that samples `pop`. `count`, `full` and `nonempty` update on the same edge.
- Simultaneous push and pop:
  - Empty: the push lands, the pop is ignored, and `count` becomes 1.
  - Full: both occur, `count` stays `DEPTH`, and `ovf` stays unchanged.
- Pointer wrap: after entry `DEPTH`-1, the next write goes to index 0. Ordering is preserved across the wrap.

## Test plan
- Reset then idle: hold `rst_in`=0 for 3 cycles, release, 10 idle cycles → `dout`=0x00, `nonempty`=0, `full`=0, `ovf`=0, `count`=0, `uart_read` never 1.
- Single byte: present 0x41 with `rx_new` high until one cycle after `uart_read`, then `pop` once.
  - After capture: exactly one `uart_read` pulse, `dout`=0x41, `count`=1.
  - After `pop`: `count`=0, `dout`=0x00.
- Fill and overflow (`DEPTH`=16): push 0x00..0x10, 17 bytes, no pops → `full`=1 after the 16th byte; the 17th byte is acknowledged and dropped; `ovf`=1; 16 pops return 0x00..0x0F in order.
- Full with push and pop in the same cycle: with the FIFO full of 0x00..0x0F, push 0xAA together with `pop` → `ovf`=0, `count`=16, head becomes 0x01; the last byte popped is 0xAA.
- Wrap-around: 40 push/pop pairs with interleaved timing and data i*3 → every popped byte matches in order, `count` never exceeds 16, `ovf`=0.
- Flags and reset corner cases:
  - Hold `rx_new` high for 5 cycles → one push only.
  - Assert `clr_ovf` in the same cycle as a new overflow → `ovf` stays 1.
  - Pulse `rst_in` low while in WAIT → all outputs return to their reset values immediately.
